// File: rtl/wb_spi_slave_if_pkg.sv
// Shared definitions for the Wishbone SPI slave front end: register word
// offsets, CTRL/STATUS bit positions, ack FSM states and termination codes.
package wb_spi_defs;

  localparam logic [2:0] REG_TX   = 3'd0;
  localparam logic [2:0] REG_RX   = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;
  localparam logic [2:0] REG_DIV  = 3'd3;
  localparam logic [2:0] REG_SS   = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd5;

  localparam int unsigned CTRL_LEN_W = 7;
  localparam int unsigned CTRL_GO    = 8;
  localparam int unsigned CTRL_LSB   = 9;
  localparam int unsigned CTRL_IE    = 12;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP,
    ST_HOLD
  } ack_state_t;

  typedef enum logic [1:0] {
    TERM_ACK,
    TERM_ERR,
    TERM_RTY
  } term_t;

  function automatic logic is_mapped_word(input logic [2:0] word);
    return word <= REG_STAT;
  endfunction

endpackage

// File: rtl/wb_spi_ack_fsm.sv
// IDLE/RESP/HOLD handshake FSM: samples a request in IDLE, responds for exactly
// one cycle, then waits in HOLD until the master drops cyc&stb.
module wb_spi_ack_fsm
  import wb_spi_defs::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_req,
  input  term_t i_term,
  output logic  o_sample,
  output logic  o_resp,
  output term_t o_term
);

  ack_state_t r_state;
  ack_state_t w_state_nxt;
  term_t      r_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_term  <= TERM_ACK;
    end else begin
      r_state <= w_state_nxt;
      if (o_sample) r_term <= i_term;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          o_sample    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_HOLD;
      ST_HOLD: if (!i_req) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_resp = (r_state == ST_RESP);
  assign o_term = r_term;

endmodule

// File: rtl/wb_spi_slave_if.sv
// Wishbone register front end of the SPI core. Optional interrupt output is
// enabled by defining WB_SPI_IRQ_EN.
module wb_spi_slave_if
  import wb_spi_defs::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned SS_NB  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AWIDTH-1:0]     adr,
  input  logic [DWIDTH-1:0]     din,
  output logic [DWIDTH-1:0]     dout,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [DWIDTH/8-1:0]   sel,
  output logic                  ack,
  output logic                  err,
  output logic                  rty,
  output logic                  go,
  input  logic                  done,
  input  logic [DWIDTH-1:0]     rx_data,
  output logic [DWIDTH-1:0]     tx_data,
  output logic [6:0]            char_len,
  output logic                  lsb,
  output logic [15:0]           divider,
  output logic [SS_NB-1:0]      ss,
  output logic                  int_o
);

  logic [DWIDTH-1:0] r_tx;
  logic [DWIDTH-1:0] r_rx;
  logic [DWIDTH-1:0] r_dout;
  logic [6:0]        r_len;
  logic              r_lsb;
  logic [15:0]       r_div;
  logic [SS_NB-1:0]  r_ss;
  logic              r_busy;
  logic              r_done;
  logic              r_go;

  logic              w_req;
  logic [2:0]        w_word;
  logic              w_adr_bad;
  term_t             w_term;
  term_t             w_term_q;
  logic              w_sample;
  logic              w_resp;
  logic              w_commit;
  logic              w_wr;
  logic              w_rd;
  logic              w_go_start;
  logic              w_done_evt;
  logic              w_done_clr;
  logic              w_ie;
  logic [DWIDTH-1:0] w_wmask;
  logic [SS_NB-1:0]  w_ss_new;
  logic [DWIDTH-1:0] w_rd_data;
  logic              w_unused;

  assign w_req     = cyc & stb;
  assign w_word    = adr[4:2];
  assign w_adr_bad = (adr[AWIDTH-1:5] != '0) || !is_mapped_word(w_word);
  assign w_unused  = ^adr[1:0];

  always_comb begin
    w_term = TERM_ACK;
    if (w_adr_bad || (we && w_word == REG_RX))
      w_term = TERM_ERR;
    else if (we && r_busy &&
             (w_word == REG_TX || (w_word == REG_CTRL && din[CTRL_GO])))
      w_term = TERM_RTY;
  end

  wb_spi_ack_fsm u_ack_fsm (
    .clk      (clk),
    .rst_n    (rst),
    .i_req    (w_req),
    .i_term   (w_term),
    .o_sample (w_sample),
    .o_resp   (w_resp),
    .o_term   (w_term_q)
  );

  // Commit happens on the IDLE->RESP edge, i.e. the same edge that raises ack.
  assign w_commit   = w_sample && (w_term == TERM_ACK);
  assign w_wr       = w_commit && we;
  assign w_rd       = w_commit && !we;
  assign w_go_start = w_wr && (w_word == REG_CTRL) && sel[1] && din[CTRL_GO];
  assign w_done_evt = done && r_busy;
  assign w_done_clr = w_wr && (w_word == REG_STAT) && sel[0] && din[STAT_DONE];

  always_comb begin
    w_wmask = '0;
    for (int unsigned i = 0; i < DWIDTH; i++) w_wmask[i] = sel[i/8];
    w_ss_new = r_ss;
    for (int unsigned i = 0; i < SS_NB; i++)
      if (sel[i/8]) w_ss_new[i] = din[i];
  end

  always_comb begin
    w_rd_data = '0;
    case (w_word)
      REG_TX:   w_rd_data = r_tx;
      REG_RX:   w_rd_data = r_rx;
      REG_CTRL: begin
        w_rd_data[CTRL_LEN_W-1:0] = r_len;
        w_rd_data[CTRL_GO]        = r_busy;
        w_rd_data[CTRL_LSB]       = r_lsb;
        w_rd_data[CTRL_IE]        = w_ie;
      end
      REG_DIV:  w_rd_data[15:0] = r_div;
      REG_SS:   w_rd_data[SS_NB-1:0] = r_ss;
      REG_STAT: begin
        w_rd_data[STAT_BUSY] = r_busy;
        w_rd_data[STAT_DONE] = r_done;
      end
      default:  w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_dout <= '0;
      r_len  <= '0;
      r_lsb  <= 1'b0;
      r_div  <= '0;
      r_ss   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_go   <= 1'b0;
    end else begin
      r_go <= w_go_start;
      if (w_rd) r_dout <= w_rd_data;
      if (w_wr) begin
        case (w_word)
          REG_TX:   r_tx <= (r_tx & ~w_wmask) | (din & w_wmask);
          REG_CTRL: begin
            if (sel[0]) r_len <= din[CTRL_LEN_W-1:0];
            if (sel[1]) r_lsb <= din[CTRL_LSB];
          end
          REG_DIV: begin
            if (sel[0]) r_div[7:0]  <= din[7:0];
            if (sel[1]) r_div[15:8] <= din[15:8];
          end
          REG_SS:   r_ss <= w_ss_new;
          default:  ;
        endcase
      end
      if (w_go_start)
        r_busy <= 1'b1;
      else if (w_done_evt)
        r_busy <= 1'b0;
      // A completing transfer outranks a simultaneous DONE clear.
      if (w_done_evt) begin
        r_rx   <= rx_data;
        r_done <= 1'b1;
      end else if (w_done_clr) begin
        r_done <= 1'b0;
      end
    end
  end

`ifdef WB_SPI_IRQ_EN
  logic r_ie;
  logic r_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ie  <= 1'b0;
      r_int <= 1'b0;
    end else begin
      if (w_wr && (w_word == REG_CTRL) && sel[1]) r_ie <= din[CTRL_IE];
      r_int <= r_ie & r_done;
    end
  end

  assign w_ie  = r_ie;
  assign int_o = r_int;
`else
  assign w_ie  = 1'b0;
  assign int_o = 1'b0;
`endif

  assign ack      = w_resp && (w_term_q == TERM_ACK);
  assign err      = w_resp && (w_term_q == TERM_ERR);
  assign rty      = w_resp && (w_term_q == TERM_RTY);
  assign go       = r_go;
  assign dout     = r_dout;
  assign tx_data  = r_tx;
  assign char_len = r_len;
  assign lsb      = r_lsb;
  assign divider  = r_div;
  assign ss       = r_ss;

endmodule

// File: tb/tb_wb_spi_slave_if.sv
// Scoreboard bench for wb_spi_slave_if; IRQ checks follow WB_SPI_IRQ_EN.
module tb_wb_spi_slave_if;

  localparam logic [1:0] T_ACK = 2'd0;
  localparam logic [1:0] T_ERR = 2'd1;
  localparam logic [1:0] T_RTY = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, din, dout, rx_data, tx_data;
  logic        cyc, stb, we, ack, err, rty, go, done, lsb, int_o;
  logic [3:0]  sel;
  logic [6:0]  char_len;
  logic [15:0] divider;
  logic [7:0]  ss;

  always #5 clk = ~clk;

  wb_spi_slave_if #(.DWIDTH(32), .AWIDTH(32), .SS_NB(8)) dut (
    .clk(clk), .rst(rst), .adr(adr), .din(din), .dout(dout), .cyc(cyc),
    .stb(stb), .we(we), .sel(sel), .ack(ack), .err(err), .rty(rty), .go(go),
    .done(done), .rx_data(rx_data), .tx_data(tx_data), .char_len(char_len),
    .lsb(lsb), .divider(divider), .ss(ss), .int_o(int_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  term;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  int unsigned n_ack = 0;
  int unsigned n_go  = 0;
  int unsigned last_lat;

  always @(negedge clk) begin
    if (ack) n_ack++;
    if (go)  n_go++;
  end

  task automatic wb(input string tag, input logic [31:0] a, input logic w,
                    input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] exp_term, input logic [31:0] exp_data,
                    input int unsigned hold, input logic with_done);
    exp_t        e;
    logic [1:0]  t;
    int unsigned lat;
    bit          got;
    e.tag = tag; e.term = exp_term; e.data = exp_data;
    e.chk_data = !w && (exp_term == T_ACK);
    sb.push_back(e);
    adr = a; we = w; din = d; sel = s; cyc = 1'b1; stb = 1'b1;
    if (with_done) done = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      done = 1'b0;
      lat++;
      if (ack || err || rty) got = 1;
    end
    e = sb.pop_front();
    if (!got) begin
      check({e.tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      t = ack ? T_ACK : (err ? T_ERR : T_RTY);
      check({e.tag, "_term"}, 32'(t), 32'(e.term));
      check({e.tag, "_excl"}, 32'(ack) + 32'(err) + 32'(rty), 32'd1);
      if (e.chk_data) check({e.tag, "_dout"}, dout, e.data);
    end
    last_lat = lat;
    repeat (hold) @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done(input logic [31:0] v);
    rx_data = v; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  int unsigned a0, g0;

  initial begin
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; din = '0;
    sel = '0; done = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",  32'(ack),   32'd0);
    check("rst_err",  32'(err),   32'd0);
    check("rst_rty",  32'(rty),   32'd0);
    check("rst_go",   32'(go),    32'd0);
    check("rst_int",  32'(int_o), 32'd0);
    check("rst_dout", dout,       32'd0);
    check("rst_tx",   tx_data,    32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    wb("rd_stat0", 32'h14, 1'b0, '0, 4'hF, T_ACK, 32'h0, 0, 1'b0);
    check("lat_one", last_lat, 32'd1);

    a0 = n_ack; g0 = n_go;
    wb("wr_ctrl_go", 32'h08, 1'b1, 32'h0000_0108, 4'hF, T_ACK, '0, 2, 1'b0);
    check("one_ack", n_ack - a0, 32'd1);
    check("one_go",  n_go - g0,  32'd1);
    check("char_len8", 32'(char_len), 32'd8);
    wb("rd_stat_busy", 32'h14, 1'b0, '0, 4'hF, T_ACK, 32'h1, 0, 1'b0);
    wb("rd_ctrl_go",   32'h08, 1'b0, '0, 4'hF, T_ACK, 32'h108, 0, 1'b0);

    wb("wr_tx_busy", 32'h00, 1'b1, 32'hA5, 4'hF, T_RTY, '0, 0, 1'b0);
    check("tx_kept", tx_data, 32'd0);
    wb("wr_ctrl_busy", 32'h08, 1'b1, 32'h108, 4'hF, T_RTY, '0, 0, 1'b0);
    check("no_rego", n_go - g0, 32'd1);
    pulse_done(32'h3C);
    wb("rd_rx",       32'h04, 1'b0, '0, 4'hF, T_ACK, 32'h3C, 0, 1'b0);
    wb("rd_stat_dn",  32'h14, 1'b0, '0, 4'hF, T_ACK, 32'h2, 0, 1'b0);
    wb("rd_ctrl_idl", 32'h08, 1'b0, '0, 4'hF, T_ACK, 32'h008, 0, 1'b0);
    pulse_done(32'h77);
    wb("rd_rx_ign",   32'h04, 1'b0, '0, 4'hF, T_ACK, 32'h3C, 0, 1'b0);
    wb("wr_stat_clr", 32'h14, 1'b1, 32'h2, 4'hF, T_ACK, '0, 0, 1'b0);
    wb("rd_stat_clr", 32'h14, 1'b0, '0, 4'hF, T_ACK, 32'h0, 0, 1'b0);

    wb("wr_rx",      32'h04, 1'b1, 32'hDEAD, 4'hF, T_ERR, '0, 0, 1'b0);
    wb("rd_rx2",     32'h04, 1'b0, '0, 4'hF, T_ACK, 32'h3C, 0, 1'b0);
    wb("rd_20",      32'h20, 1'b0, '0, 4'hF, T_ERR, '0, 0, 1'b0);
    check("dout_held", dout, 32'h3C);
    wb("rd_18",      32'h18, 1'b0, '0, 4'hF, T_ERR, '0, 0, 1'b0);
    wb("rd_hi",      32'h1000_0008, 1'b0, '0, 4'hF, T_ERR, '0, 0, 1'b0);

    wb("wr_div", 32'h0C, 1'b1, 32'hFFFF_1234, 4'b0001, T_ACK, '0, 0, 1'b0);
    wb("rd_div", 32'h0C, 1'b0, '0, 4'hF, T_ACK, 32'h34, 0, 1'b0);
    check("divider", 32'(divider), 32'h34);
    wb("wr_tx",   32'h00, 1'b1, 32'hA5, 4'hF, T_ACK, '0, 0, 1'b0);
    wb("wr_tx_b2", 32'h00, 1'b1, 32'hFFFF_FFFF, 4'b0100, T_ACK, '0, 0, 1'b0);
    check("tx_data", tx_data, 32'h00FF_00A5);
    wb("wr_ss", 32'h10, 1'b1, 32'hABCD, 4'hF, T_ACK, '0, 0, 1'b0);
    check("ss", 32'(ss), 32'hCD);
    g0 = n_go;
    wb("wr_ctrl_lsb", 32'h08, 1'b1, 32'h200, 4'hF, T_ACK, '0, 0, 1'b0);
    check("lsb", 32'(lsb), 32'd1);
    check("lsb_nogo", n_go - g0, 32'd0);

    wb("wr_ctrl_go2", 32'h08, 1'b1, 32'h108, 4'hF, T_ACK, '0, 0, 1'b0);
    wb("clr_vs_done", 32'h14, 1'b1, 32'h2, 4'hF, T_ACK, '0, 0, 1'b1);
    wb("rd_set_wins", 32'h14, 1'b0, '0, 4'hF, T_ACK, 32'h2, 0, 1'b0);
    wb("wr_stat_clr2", 32'h14, 1'b1, 32'h2, 4'hF, T_ACK, '0, 0, 1'b0);

`ifdef WB_SPI_IRQ_EN
    wb("wr_ctrl_ie", 32'h08, 1'b1, 32'h1108, 4'hF, T_ACK, '0, 0, 1'b0);
    check("int_pre", 32'(int_o), 32'd0);
    pulse_done(32'h11);
    repeat (2) @(posedge clk);
    #1;
    check("int_set", 32'(int_o), 32'd1);
    wb("rd_ctrl_ie", 32'h08, 1'b0, '0, 4'hF, T_ACK, 32'h1008, 0, 1'b0);
    wb("wr_stat_int", 32'h14, 1'b1, 32'h2, 4'hF, T_ACK, '0, 0, 1'b0);
    check("int_clr", 32'(int_o), 32'd0);
`else
    wb("wr_ctrl_ie", 32'h08, 1'b1, 32'h1008, 4'hF, T_ACK, '0, 0, 1'b0);
    wb("rd_ctrl_noie", 32'h08, 1'b0, '0, 4'hF, T_ACK, 32'h0008, 0, 1'b0);
    check("int_tied", 32'(int_o), 32'd0);
`endif

    adr = 32'h14; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("resp_ack", 32'(ack), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_drop_ack", 32'(ack), 32'd0);
    check("rst_len", 32'(char_len), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    wb("rd_ctrl_rst", 32'h08, 1'b0, '0, 4'hF, T_ACK, 32'h0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
